burst_memory: RTL
=================

// Module: burst_memory
// PURPOSE
//  Parametrised single-port synchronous memory, next generation of the 8-bit Memory block.
//  Adds width/depth parameters, asynchronous active-low reset with a hardware clear sweep,
//  and address-incrementing burst reads/writes with wrap-around.
//  Sits between the datapath/bus master and storage; single accesses are bursts of length 1.
// PARAMETERS
//  DATA_WIDTH  8  word width in bits
//  ADDR_WIDTH  8  address width; depth = 2**ADDR_WIDTH words
//  INIT_VALUE  0  word written to every location by the post-reset clear sweep
// PORTS
//  clock      in   1           single clock; all state changes on rising edge
//  reset_n    in   1           asynchronous, active-low reset
//  cs         in   1           chip select, active low (0 = enabled)
//  wr         in   1           0 = read, 1 = write; sampled with start
//  start      in   1           request a burst; accepted only when ready=1 and cs=0
//  address    in   ADDR_WIDTH  burst start address, sampled with start
//  burst_len  in   ADDR_WIDTH  beats minus one (0 = single word), sampled with start
//  data       in   DATA_WIDTH  write data, consumed on beats with data_valid=1
//  data_valid in   1           write beat qualifier
//  o          out  DATA_WIDTH  read data
//  o_valid    out  1           o holds a read beat this cycle
//  ready      out  1           1 in IDLE only
//  busy       out  1           1 in INIT (clear sweep)
//  done       out  1           1-cycle pulse when a burst ends or is aborted
// BEHAVIOUR
//  Reset (reset_n=0, async): state=INIT, sweep ptr=0, o=0, o_valid=0, ready=0, busy=1, done=0.
//  States INIT -> IDLE -> BURST -> IDLE.
//  INIT: one word per cycle, mem[ptr]=INIT_VALUE, ptr 0..2**ADDR_WIDTH-1; after last write
//   -> IDLE (busy=0, ready=1 next cycle). start/cs ignored in INIT; sweep = 2**ADDR_WIDTH cycles.
//  IDLE: start=1 & cs=0 captures address->ptr, wr, burst_len->remaining; -> BURST.
//   start with cs=1 ignored. No access occurs in the capture cycle.
//  BURST write: each cycle with data_valid=1 and cs=0: mem[ptr]=data, ptr++, remaining--.
//   data_valid=0 stalls (no write, no advance).
//  BURST read: one beat per cycle while cs=0: o=mem[ptr] registered, o_valid=1 the following
//   cycle (1-cycle latency), ptr++, remaining--. No backpressure on reads.
//  Address arithmetic mod 2**ADDR_WIDTH: ptr wraps all-ones -> 0 within a burst.
//  Final beat (remaining==0 when beat taken): -> IDLE, done=1 in the next cycle.
//  Abort: cs=1 during BURST -> IDLE next edge, done=1; read beat issued the previous cycle
//   still appears on o with o_valid=1; no further beats.
//  start during BURST ignored (no queueing). o holds last read value when o_valid=0.
//  Reset mid-burst or mid-sweep: immediate return to reset values; sweep restarts from 0,
//   so prior contents are lost by design.
//  Max burst = 2**ADDR_WIDTH beats (burst_len all ones) covers every word exactly once.
// TESTING (DATA_WIDTH=8, ADDR_WIDTH=8, INIT_VALUE=8'hA5 unless noted)
//  1 Reset release -> busy=1 for 256 cycles then ready=1; single reads of 0x00,0x7F,0xFF
//    return 8'hA5 with o_valid 1 cycle after each beat.
//  2 Write burst addr=0x10 len=3 data 11,22,33,44 (data_valid gap after 22) -> 4 writes, done
//    once; read burst addr=0x10 len=3 -> o=11,22,33,44 on consecutive cycles.
//  3 Write burst addr=0xFE len=3 data 01..04 -> mem[FE]=01,[FF]=02,[00]=03,[01]=04; read-back
//    addr=0xFE len=3 matches (wrap verified).
//  4 Read burst addr=0x10 len=7, cs=1 after 2nd beat -> exactly 2 o_valid pulses (11,22),
//    done=1 once, ready=1 next cycle; start with cs=1 in IDLE -> no activity.
//  5 Assert reset_n=0 mid write burst (after 2 beats) -> outputs to reset values
//    asynchronously (before next edge); after release, sweep reruns and mem[0x10] reads 8'hA5.
//  6 start held high during BURST and INIT -> ignored; only the IDLE capture produces a burst.

Source files
------------

// File: rtl/burst_memory.sv
// Parametrised single-port synchronous memory with a post-reset clear sweep and
// address-incrementing burst reads/writes that wrap modulo the memory depth.
module burst_memory #(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  cs,
   input  logic                  wr,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [ADDR_WIDTH-1:0] burst_len,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  data_valid,
   output logic [DATA_WIDTH-1:0] o,
   output logic                  o_valid,
   output logic                  ready,
   output logic                  busy,
   output logic                  done
);

   localparam int                    DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = '1;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_BURST
   } state_t;

   state_t                  state_q,     state_d;
   logic [ADDR_WIDTH-1:0]   ptr_q,       ptr_d;
   logic [ADDR_WIDTH-1:0]   remaining_q, remaining_d;
   logic                    wr_q,        wr_d;
   logic [DATA_WIDTH-1:0]   o_q,         o_d;
   logic                    o_valid_q,   o_valid_d;
   logic                    ready_q,     ready_d;
   logic                    busy_q,      busy_d;
   logic                    done_q,      done_d;

   logic                    mem_we;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   // The sweep pointer and the burst pointer share ptr_q; every access uses it.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      remaining_d = remaining_q;
      wr_d        = wr_q;
      o_d         = o_q;
      o_valid_d   = 1'b0;
      ready_d     = ready_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      mem_we      = 1'b0;
      mem_wdata   = data;

      case (state_q)
         ST_INIT: begin
            mem_we    = 1'b1;
            mem_wdata = INIT_VALUE;
            ptr_d     = ptr_q + PTR_ONE;
            if (ptr_q == PTR_LAST) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               ready_d = 1'b1;
            end
         end

         ST_IDLE: begin
            if (start && !cs) begin
               state_d     = ST_BURST;
               ptr_d       = address;
               wr_d        = wr;
               remaining_d = burst_len;
               ready_d     = 1'b0;
            end
         end

         ST_BURST: begin
            if (cs) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               ready_d = 1'b1;
            end else if (!wr_q || data_valid) begin
               if (wr_q) begin
                  mem_we = 1'b1;
               end else begin
                  o_d       = mem_q[ptr_q];
                  o_valid_d = 1'b1;
               end
               ptr_d       = ptr_q + PTR_ONE;
               remaining_d = remaining_q - PTR_ONE;
               if (remaining_q == '0) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                  ready_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_INIT;
            ptr_d   = '0;
            busy_d  = 1'b1;
            ready_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_INIT;
         ptr_q       <= '0;
         remaining_q <= '0;
         wr_q        <= 1'b0;
         o_q         <= '0;
         o_valid_q   <= 1'b0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b1;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         remaining_q <= remaining_d;
         wr_q        <= wr_d;
         o_q         <= o_d;
         o_valid_q   <= o_valid_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Storage has no reset; the clear sweep is what gives it defined contents.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem_q[ptr_q] <= mem_wdata;
      end
   end

   assign o       = o_q;
   assign o_valid = o_valid_q;
   assign ready   = ready_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule
